// File: rtl/updi_pkg.sv
// Shared UPDI definitions: transmitter state encoding and frame constants.
package updi_pkg;

    typedef enum logic [3:0] {
        IDLE,
        POP,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BREAK,
        BRK_STOP
    } tx_state_e;

    localparam logic [7:0]  UPDI_SYNCH      = 8'h55;
    localparam int unsigned UPDI_DATA_BITS  = 8;
    localparam int unsigned UPDI_STOP_BITS  = 2;
    localparam int unsigned UPDI_FRAME_BITS = 12;

endpackage

// File: rtl/updi_baud_gen.sv
// UPDI bit-period generator: down-counter that pulses bit_tick in the last cycle of each bit.
// A restart reloads the counter so the next bit begins in the following cycle.
module updi_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == '0);

endmodule

// File: rtl/updi_tx.sv
// UPDI 8E2 transmitter: pops bytes from the TX FIFO and serialises them onto the single-wire line.
// Optional BREAK generation is built only when UPDI_TX_BREAK_EN is defined.
//
// state    | meaning
// IDLE     | line high, waiting for a byte (or a BREAK request)
// POP      | FIFO read strobe issued
// LATCH    | FIFO data captured into shifter, parity computed
// START    | start bit (low)
// DATA     | 8 data bits, LSB first
// PARITY   | even parity bit
// STOP1    | first stop bit (high)
// STOP2    | second stop bit (high), byte_sent in last cycle
// BREAK    | line held low for BREAK_BITS bit-times
// BRK_STOP | line driven high for 2 bit-times, break_done in last cycle
module updi_tx
    import updi_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned BREAK_BITS   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_out,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic       send_break,
    output logic       tx,
    output logic       tx_en,
    output logic       busy,
    output logic       byte_sent,
    output logic       break_done
);

    localparam logic [2:0] LAST_DATA = 3'(UPDI_DATA_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] sh_q, sh_d;
    logic       par_q, par_d;
    logic [2:0] idx_q, idx_d;
    logic       restart;
    logic       bit_tick;

`ifdef UPDI_TX_BREAK_EN
    localparam int unsigned BW = (BREAK_BITS > 1) ? $clog2(BREAK_BITS) : 1;
    localparam logic [2:0] LAST_STOP = 3'(UPDI_STOP_BITS - 1);
    logic [BW-1:0] brk_q, brk_d;
`else
    localparam int unsigned brk_bits_unused = BREAK_BITS;
    logic send_break_unused;
    assign send_break_unused = send_break;
`endif

    updi_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        par_d      = par_q;
        idx_d      = idx_q;
        restart    = 1'b0;
        byte_sent  = 1'b0;
        break_done = 1'b0;
`ifdef UPDI_TX_BREAK_EN
        brk_d      = brk_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UPDI_TX_BREAK_EN
                if (send_break) begin
                    restart = 1'b1;
                    brk_d   = BW'(BREAK_BITS - 1);
                    state_d = BREAK;
                end else if (!fifo_empty) begin
                    state_d = POP;
                end
`else
                if (!fifo_empty) begin
                    state_d = POP;
                end
`endif
            end
            POP: state_d = LATCH;
            LATCH: begin
                // Restart aligns the first bit period with the first START cycle.
                sh_d    = fifo_out;
                par_d   = ^fifo_out;
                idx_d   = '0;
                restart = 1'b1;
                state_d = START;
            end
            START: if (bit_tick) state_d = DATA;
            DATA: begin
                if (bit_tick) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST_DATA) state_d = PARITY;
                end
            end
            PARITY: if (bit_tick) state_d = STOP1;
            STOP1:  if (bit_tick) state_d = STOP2;
            STOP2: begin
                if (bit_tick) begin
                    byte_sent = 1'b1;
                    state_d   = IDLE;
                end
            end
`ifdef UPDI_TX_BREAK_EN
            BREAK: begin
                if (bit_tick) begin
                    if (brk_q == '0) begin
                        idx_d   = '0;
                        state_d = BRK_STOP;
                    end else begin
                        brk_d = brk_q - 1'b1;
                    end
                end
            end
            BRK_STOP: begin
                if (bit_tick) begin
                    if (idx_q == LAST_STOP) begin
                        break_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx    = 1'b1;
        tx_en = 1'b0;
        case (state_q)
            START:  begin tx = 1'b0;    tx_en = 1'b1; end
            DATA:   begin tx = sh_q[0]; tx_en = 1'b1; end
            PARITY: begin tx = par_q;   tx_en = 1'b1; end
            STOP1, STOP2: tx_en = 1'b1;
`ifdef UPDI_TX_BREAK_EN
            BREAK:  begin tx = 1'b0;    tx_en = 1'b1; end
            BRK_STOP: tx_en = 1'b1;
`endif
            default: ;
        endcase
    end

    assign fifo_rd_en = (state_q == POP);
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
`ifdef UPDI_TX_BREAK_EN
            brk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
`ifdef UPDI_TX_BREAK_EN
            brk_q   <= brk_d;
`endif
        end
    end

endmodule

// File: tb/tb_updi_tx.sv
// Directed bench for updi_tx with CLKS_PER_BIT=4 and a queue-backed FIFO clocked on the falling edge.
module tb_updi_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fifo_out = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic       send_break = 1'b0;
    logic       tx, tx_en, busy, byte_sent, break_done;

    logic [7:0] fifo_q[$];
    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int bs_cnt = 0;
    int bd_cnt = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    updi_tx #(.CLKS_PER_BIT(CPB), .BREAK_BITS(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_out  (fifo_out),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .send_break(send_break),
        .tx        (tx),
        .tx_en     (tx_en),
        .busy      (busy),
        .byte_sent (byte_sent),
        .break_done(break_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) begin
            rd_cnt++;
            if (fifo_q.size() > 0) fifo_out = fifo_q.pop_front();
        end
        if (byte_sent === 1'b1) bs_cnt++;
        if (break_done === 1'b1) bd_cnt++;
        fifo_empty = (fifo_q.size() == 0);
    end

    // Records one frame starting at the first negedge where tx is low.
    task automatic capture_frame(output logic [11:0] bits, output logic steady,
                                 output logic [47:0] en, output logic [47:0] bs,
                                 output logic found);
        logic [47:0] line;
        line = '0; en = '0; bs = '0; bits = '0; steady = 1'b1; found = 1'b0;
        for (int i = 0; i < 300 && tx !== 1'b0; i++) @(negedge clk);
        if (tx === 1'b0) begin
            found = 1'b1;
            for (int c = 0; c < 48; c++) begin
                if (c != 0) @(negedge clk);
                line[c] = tx;
                en[c]   = tx_en;
                bs[c]   = byte_sent;
            end
            for (int k = 0; k < 12; k++) begin
                bits[k] = line[4*k];
                for (int j = 1; j < 4; j++)
                    if (line[4*k+j] !== line[4*k]) steady = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        logic [5:0] obs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {tx, tx_en, busy, fifo_rd_en, byte_sent, break_done};
        total++;
        if (obs !== 6'b100000) begin
            bad++;
            $display("FAIL reset_state got=%b want=100000", obs);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = {tx, tx_en, busy, fifo_rd_en, byte_sent, break_done};
            total++;
            if (obs !== 6'b100000) begin
                bad++;
                $display("FAIL idle_empty cycle=%0d got=%b want=100000", i, obs);
            end
        end
        total++;
        if (rd_cnt !== 0) begin
            bad++;
            $display("FAIL idle_no_pop got=%0d want=0", rd_cnt);
        end
    endtask

    task automatic test_single;
        logic [11:0] bits;
        logic [47:0] en, bs;
        logic steady, found;
        int t0, t1;
        @(negedge clk);
        fifo_q.push_back(8'h55);
        t0 = -100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) begin
                t0 = cyc;
                break;
            end
        end
        for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
        t1 = cyc;
        total++;
        if (t1 - t0 !== 2) begin
            bad++;
            $display("FAIL pop_to_start got=%0d want=2", t1 - t0);
        end
        capture_frame(bits, steady, en, bs, found);
        total++;
        if (found !== 1'b1) begin
            bad++;
            $display("FAIL frame55_timeout got=%b want=1", found);
        end
        total++;
        if (bits !== 12'hCAA) begin
            bad++;
            $display("FAIL frame55_bits got=%h want=caa", bits);
        end
        total++;
        if (steady !== 1'b1) begin
            bad++;
            $display("FAIL frame55_bit_width got=%b want=1", steady);
        end
        total++;
        if (en !== {48{1'b1}}) begin
            bad++;
            $display("FAIL frame55_tx_en got=%h want=ffffffffffff", en);
        end
        total++;
        if (bs !== {1'b1, 47'b0}) begin
            bad++;
            $display("FAIL frame55_byte_sent got=%h want=800000000000", bs);
        end
        @(negedge clk);
        total++;
        if ({tx, tx_en, busy} !== 3'b100) begin
            bad++;
            $display("FAIL frame55_end got=%b want=100", {tx, tx_en, busy});
        end
    endtask

    task automatic test_parity;
        logic [7:0]  vin[2]  = '{8'h01, 8'h00};
        logic [11:0] vexp[2] = '{12'hE02, 12'hC00};
        logic [11:0] bits;
        logic [47:0] en, bs;
        logic steady, found;
        for (int v = 0; v < 2; v++) begin
            repeat (2) @(negedge clk);
            fifo_q.push_back(vin[v]);
            capture_frame(bits, steady, en, bs, found);
            total++;
            if (bits !== vexp[v] || found !== 1'b1) begin
                bad++;
                $display("FAIL parity_frame byte=%h got=%h want=%h", vin[v], bits, vexp[v]);
            end
            total++;
            if (steady !== 1'b1 || bs !== {1'b1, 47'b0}) begin
                bad++;
                $display("FAIL parity_timing byte=%h steady=%b bs=%h want steady=1 bs=800000000000",
                         vin[v], steady, bs);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] bits;
        logic [47:0] en, bs;
        logic steady, found;
        int rd0, bs0, gap;
        repeat (3) @(negedge clk);
        rd0 = rd_cnt;
        bs0 = bs_cnt;
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'hE5);
        capture_frame(bits, steady, en, bs, found);
        total++;
        if (bits !== 12'hCAA) begin
            bad++;
            $display("FAIL b2b_first got=%h want=caa", bits);
        end
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) break;
            gap++;
        end
        total++;
        if (gap !== 3) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=3", gap);
        end
        capture_frame(bits, steady, en, bs, found);
        total++;
        if (bits !== 12'hFCA || steady !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second got=%h steady=%b want=fca steady=1", bits, steady);
        end
        repeat (10) @(negedge clk);
        total++;
        if (rd_cnt - rd0 !== 2) begin
            bad++;
            $display("FAIL b2b_pops got=%0d want=2", rd_cnt - rd0);
        end
        total++;
        if (bs_cnt - bs0 !== 2) begin
            bad++;
            $display("FAIL b2b_byte_sent got=%0d want=2", bs_cnt - bs0);
        end
    endtask

    task automatic test_reset_midframe;
        logic [11:0] bits;
        logic [47:0] en, bs;
        logic steady, found;
        int rd0, bs0;
        repeat (2) @(negedge clk);
        rd0 = rd_cnt;
        bs0 = bs_cnt;
        fifo_q.push_back(8'h34);
        fifo_q.push_back(8'h0F);
        for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({tx, tx_en, busy} !== 3'b100) begin
            bad++;
            $display("FAIL rst_mid_line got=%b want=100", {tx, tx_en, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bs_cnt !== bs0) begin
            bad++;
            $display("FAIL rst_mid_byte_sent got=%0d want=%0d", bs_cnt, bs0);
        end
        capture_frame(bits, steady, en, bs, found);
        total++;
        if (bits !== 12'hC1E || found !== 1'b1 || bs !== {1'b1, 47'b0}) begin
            bad++;
            $display("FAIL rst_mid_next got=%h bs=%h want=c1e bs=800000000000", bits, bs);
        end
        repeat (8) @(negedge clk);
        total++;
        if (rd_cnt - rd0 !== 2 || bs_cnt - bs0 !== 1) begin
            bad++;
            $display("FAIL rst_mid_counts pops=%0d sent=%0d want pops=2 sent=1",
                     rd_cnt - rd0, bs_cnt - bs0);
        end
    endtask

`ifdef UPDI_TX_BREAK_EN
    task automatic test_break;
        logic [11:0] bits;
        logic [47:0] en, bs;
        logic steady, found;
        int rd0, bs0, lo, hi, bdpos, gap;
        repeat (2) @(negedge clk);
        rd0 = rd_cnt;
        bs0 = bs_cnt;
        send_break = 1'b1;
        fifo_q.push_back(8'h55);
        for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
        send_break = 1'b0;
        lo = 0;
        while (tx === 1'b0 && tx_en === 1'b1 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        total++;
        if (lo !== 48) begin
            bad++;
            $display("FAIL break_low got=%0d want=48", lo);
        end
        total++;
        if (rd_cnt !== rd0) begin
            bad++;
            $display("FAIL break_no_pop got=%0d want=%0d", rd_cnt, rd0);
        end
        hi = 0;
        bdpos = -1;
        while (tx === 1'b1 && tx_en === 1'b1 && hi < 50) begin
            if (break_done === 1'b1) bdpos = hi;
            hi++;
            @(negedge clk);
        end
        total++;
        if (hi !== 8 || bdpos !== 7) begin
            bad++;
            $display("FAIL break_stop high=%0d done_at=%0d want high=8 done_at=7", hi, bdpos);
        end
        gap = 0;
        while (tx === 1'b1 && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        total++;
        if (gap !== 3) begin
            bad++;
            $display("FAIL break_gap got=%0d want=3", gap);
        end
        capture_frame(bits, steady, en, bs, found);
        total++;
        if (bits !== 12'hCAA || bd_cnt !== 1 || bs_cnt - bs0 !== 1) begin
            bad++;
            $display("FAIL break_then_frame bits=%h done=%0d sent=%0d want caa 1 1",
                     bits, bd_cnt, bs_cnt - bs0);
        end
        repeat (3) @(negedge clk);
    endtask
`else
    task automatic test_break;
        logic [2:0] obs;
        send_break = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = {tx, busy, break_done};
            total++;
            if (obs !== 3'b100) begin
                bad++;
                $display("FAIL break_ignored cycle=%0d got=%b want=100", i, obs);
            end
        end
        send_break = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_parity;
        test_back_to_back;
        test_reset_midframe;
        test_break;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
